mips_mc_ctrl: RTL
=================

Name: mips_mc_ctrl

Overview:
- Multi-cycle instruction controller that drives the single-cycle ALU datapath.
- Fetches from instruction memory, decodes, and generates the ALU control word (opcode, funct, shamt, sign-extended immediate, ALUOp, ALUSrc).
- Resolves branches and overflow from the ALU's returned alu_result/alu_overflow.
- Sequences register-file and data-memory strobes; sits between imem/dmem and the register file + ALU.

Parameters:
- ADDR_W, 32, PC / instruction address width (byte addressed, word aligned)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock
- srstn  in  1  reset, synchronous, active-low
- start  in  1  pulse: leave IDLE and begin fetching at current PC
- imem_en  out  1  instruction read strobe
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_rdata  in  32  instruction; valid exactly 1 cycle after imem_en
- rs_addr, rt_addr  out  5 each  register-file read addresses (IR[25:21], IR[20:16])
- opcode  out  6  IR[31:26] to ALU
- funct  out  6  IR[5:0] to ALU
- shamt  out  5  IR[10:6] to ALU
- immd  out  32  sign-extended IR[15:0]
- ALUOp  out  2  00 add (ADDI/LW/SW), 01 sub (BEQ), 10 R-type
- ALUSrc  out  1  1 = immd as second operand
- alu_result  in  32  signed ALU result
- alu_overflow  in  1  ALU overflow flag
- dmem_en  out  1  data memory strobe
- dmem_we  out  1  1 = write (SW)
- dmem_addr  out  32  registered ALU result
- reg_we  out  1  register-file write strobe
- reg_waddr  out  5  rd (R-type) or rt (ADDI/LW)
- wb_sel  out  1  1 = write data from dmem (LW), 0 = from ALU result register
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- ovf_exc  out  1  1-cycle pulse on suppressed overflowing write
- illegal  out  1  1-cycle pulse on unsupported opcode/funct

Behaviour:
- Reset (srstn=0 at posedge):
  - state=IDLE, PC=RESET_PC, IR=0, ALU-out register=0.
  - All strobes, flags and control outputs 0; immd=0; ALUOp=00.
  - Reset mid-instruction aborts it with no memory or register write.
- Supported instructions:
  - R-type (opcode 000000): funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 101000, SLT 101010, SLL 000011, SRL 000010, NOP 000000.
  - ADDI 001000, LW 100011, SW 101011, BEQ 000100.
  - HALT = 32'hFFFF_FFFF.
- FSM states and transitions:
  - IDLE: wait for start → IF.
  - IF: imem_en=1, imem_addr=PC → ID.
  - ID: latch imem_rdata into IR; PC ← PC+4.
    - HALT → DONE.
    - Illegal opcode, or R-type with unlisted funct: pulse illegal → IF (acts as NOP).
    - Otherwise → EX.
  - EX: control outputs decoded from IR (held stable from ID through WB); register alu_result into ALU-out.
    - BEQ: if alu_result==0 then PC ← PC + (immd<<2) (PC already +4); → IF.
    - LW/SW → MEM. Others → WB.
  - MEM: dmem_en=1, dmem_addr=ALU-out; dmem_we=1 for SW.
    - SW → IF. LW → WB (read data valid next cycle).
  - WB: reg_we=1 unless rd/rt==0, funct==NOP, or overflow suppression applies; wb_sel=1 only for LW → IF.
  - DONE: hold; done=1; start ignored; only reset exits.
- Cycle counts: BEQ 3; R-type/ADDI 4; SW 4; LW 5; illegal 2.
- Overflow:
  - Honoured only for ADD, SUB, ADDI.
  - alu_overflow captured in EX; if set, WB suppresses reg_we and pulses ovf_exc in WB.
  - For all other operations the overflow flag is ignored.
- PC wraps modulo 2^ADDR_W. Branch offset arithmetic is two's complement in ADDR_W bits.
- start while busy is ignored.

Decomposition:
- Package mips_pkg:
  - opcode and funct localparams
  - ALUOp encodings
  - FSM state enum
  - HALT constant
- Sub-module mips_decode (combinational): IR → ALUOp, ALUSrc, reg_waddr, wb_sel, mem/branch/legal/ovf-check flags.
- mips_mc_ctrl holds the FSM, PC, IR and ALU-out register.

Test Plan:
- Reset then start, imem[0]=ADDI r1,r0,5 (0x20010005): ALUOp=00, ALUSrc=1, immd=5 in EX; reg_we=1, reg_waddr=1 in WB 4 cycles after start; PC=4.
- BEQ with alu_result=0, immd=-2, fetched at PC=8 → next imem_addr=4. Same with alu_result=7 → next imem_addr=12.
- LW r2,16(r0): dmem_en=1, dmem_we=0, dmem_addr=16 in MEM; next cycle reg_we=1, wb_sel=1, reg_waddr=2; 5 cycles total. SW: dmem_we=1, no reg_we.
- ADD with alu_overflow=1 → reg_we=0, ovf_exc pulse in WB. AND with alu_overflow=1 → reg_we=1, no ovf_exc.
- Opcode 111111 (non-HALT) → illegal pulse, no writes, next fetch at PC+4. HALT → done=1 held; further start ignored.
- srstn=0 during MEM of SW → no dmem_we pulse, PC=RESET_PC, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALUOp codes, FSM states and the decoded-instruction bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b101000;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000011;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_NOP = 6'b000000;

  localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_DONE
  } state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src;
    logic [4:0] waddr;
    logic       wb_sel;
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       legal;
    logic       ovf_chk;
    logic       wr_en;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decoder: one 32-bit instruction word in,
// datapath control and classification flags out.
module mips_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    // NOTE: every field gets a default first so no decode path infers a latch.
    dec = '0;
    if (instr == INSTR_HALT) begin
      dec.halt = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          dec.alu_op = ALU_RTYPE;
          dec.waddr  = instr[15:11];
          case (fn)
            FN_ADD, FN_SUB: begin
              dec.legal   = 1'b1;
              dec.ovf_chk = 1'b1;
              dec.wr_en   = 1'b1;
            end
            FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL, FN_SRL: begin
              dec.legal = 1'b1;
              dec.wr_en = 1'b1;
            end
            FN_NOP:  dec.legal = 1'b1;
            default: dec.legal = 1'b0;
          endcase
        end
        OP_ADDI: begin
          dec.alu_src = 1'b1;
          dec.waddr   = instr[20:16];
          dec.legal   = 1'b1;
          dec.ovf_chk = 1'b1;
          dec.wr_en   = 1'b1;
        end
        OP_LW: begin
          dec.alu_src = 1'b1;
          dec.waddr   = instr[20:16];
          dec.wb_sel  = 1'b1;
          dec.is_mem  = 1'b1;
          dec.legal   = 1'b1;
          dec.wr_en   = 1'b1;
        end
        OP_SW: begin
          dec.alu_src  = 1'b1;
          dec.is_mem   = 1'b1;
          dec.is_store = 1'b1;
          dec.legal    = 1'b1;
        end
        OP_BEQ: begin
          dec.alu_op    = ALU_SUB;
          dec.is_branch = 1'b1;
          dec.legal     = 1'b1;
        end
        default: dec.legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS instruction controller: FSM, PC, IR and ALU-out register
// sequencing imem, ALU, dmem and register-file writeback.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        shamt,
  output logic [31:0]       immd,
  output logic [1:0]        ALUOp,
  output logic              ALUSrc,
  input  logic [31:0]       alu_result,
  input  logic              alu_overflow,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic              reg_we,
  output logic [4:0]        reg_waddr,
  output logic              wb_sel,
  output logic              busy,
  output logic              done,
  output logic              ovf_exc,
  output logic              illegal
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, br_off;
  logic [31:0]       ir, alu_out, dec_instr;
  logic              ovf_q, ctrl_active;
  dec_t              dec;

  // In ID the word being fetched is decoded directly so HALT/illegal resolve
  // without waiting for IR; every later state decodes the latched IR.
  assign dec_instr = (state == S_ID) ? imem_rdata : ir;

  mips_decode u_decode (
    .instr (dec_instr),
    .dec   (dec)
  );

  assign opcode  = ir[31:26];
  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign immd    = {{16{ir[15]}}, ir[15:0]};
  assign br_off  = ADDR_W'($signed(immd)) << 2;

  assign ctrl_active = (state == S_EX) || (state == S_MEM) || (state == S_WB);
  assign ALUOp       = ctrl_active ? dec.alu_op  : ALU_ADD;
  assign ALUSrc      = ctrl_active && dec.alu_src;
  assign reg_waddr   = ctrl_active ? dec.waddr   : 5'd0;
  assign wb_sel      = ctrl_active && dec.wb_sel;

  assign imem_addr = pc;
  assign dmem_addr = alu_out;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!srstn) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      alu_out <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_ID) ir <= imem_rdata;
      if (state == S_EX) begin
        alu_out <= alu_result;
        ovf_q   <= alu_overflow && dec.ovf_chk;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    imem_en   = 1'b0;
    dmem_en   = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    ovf_exc   = 1'b0;
    // Strobes are masked while reset is asserted so an aborted access never reaches memory.
    if (srstn) begin
      case (state)
        S_IDLE: if (start) state_nxt = S_IF;
        S_IF: begin
          imem_en   = 1'b1;
          state_nxt = S_ID;
        end
        S_ID: begin
          pc_nxt = pc + ADDR_W'(4);
          if (dec.halt) begin
            state_nxt = S_DONE;
          end else if (!dec.legal) begin
            illegal   = 1'b1;
            state_nxt = S_IF;
          end else begin
            state_nxt = S_EX;
          end
        end
        S_EX: begin
          if (dec.is_branch) begin
            if (alu_result == 32'd0) pc_nxt = pc + br_off;
            state_nxt = S_IF;
          end else if (dec.is_mem) begin
            state_nxt = S_MEM;
          end else begin
            state_nxt = S_WB;
          end
        end
        S_MEM: begin
          dmem_en   = 1'b1;
          dmem_we   = dec.is_store;
          state_nxt = dec.is_store ? S_IF : S_WB;
        end
        S_WB: begin
          reg_we    = dec.wr_en && (dec.waddr != 5'd0) && !ovf_q;
          ovf_exc   = ovf_q;
          state_nxt = S_IF;
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
